// File: rtl/bus_trig_reg_to_if.sv
// Register bus between a master and the bus_trig_reg_to slave.
// Handshake: req is sampled on every bus_clk edge and has no ready; a request to a decoded
// address is acked for exactly one cycle after the edge that sampled it, and rd_data is zero
// whenever ack is low.
interface bus_trig_reg_to_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          rd_wr_l;
  logic [DW-1:0] wr_data;
  logic          ack;
  logic [DW-1:0] rd_data;

  modport master (output req, addr, rd_wr_l, wr_data, input ack, rd_data);
  modport slave  (input req, addr, rd_wr_l, wr_data, output ack, rd_data);
endinterface

// File: rtl/bus_trig_reg_to.sv
// Trigger-on-write command register: software sets out bits, hardware completes them on an
// in rise or they expire, with sticky DONE/TMO status, ABORT, and optional pulse-mode bits.
module bus_trig_reg_to #(
  parameter int                   ADDR      = 0,
  parameter int                   OFFSET    = 0,
  parameter int                   DATAWIDTH = 32,
  parameter int                   TIMEOUT   = 0,
  parameter int                   TOWIDTH   = 16,
  parameter logic [DATAWIDTH-1:0] PULSE     = '0,
  parameter int                   BUS_AW    = 16,
  parameter int                   BUS_DW    = 32
) (
  input  logic                 bus_clk,
  input  logic                 bus_reset_l,
  bus_trig_reg_to_if.slave     bus,
  input  logic [DATAWIDTH-1:0] in,
  output logic [DATAWIDTH-1:0] out
);

  localparam int                 WIDE    = DATAWIDTH + OFFSET + BUS_DW;
  localparam logic [BUS_AW-1:0]  BASE    = BUS_AW'(ADDR);
  localparam logic [TOWIDTH-1:0] TO_LAST = TOWIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [DATAWIDTH-1:0] out_q, out_d;
  logic [DATAWIDTH-1:0] done_q, done_d, done_set;
  logic [DATAWIDTH-1:0] tmo_q, tmo_d, tmo_set;
  logic [DATAWIDTH-1:0] in_q, det;
  logic [TOWIDTH-1:0]   cnt_q [DATAWIDTH];
  logic [TOWIDTH-1:0]   cnt_d [DATAWIDTH];
  logic                 ack_q;
  logic [BUS_DW-1:0]    rdata_q, rdata_d;

  // Address decode: subtracting the base folds both range bounds into one unsigned compare.
  logic [BUS_AW-1:0]    addr_rel;
  logic                 hit, rd, wr;
  logic [1:0]           reg_sel;
  logic [DATAWIDTH-1:0] wf, field;
  logic                 wr_cmd, wr_done, wr_tmo, wr_abort;

  assign addr_rel = bus.addr - BASE;
  assign hit      = bus.req && (addr_rel[BUS_AW-1:2] == '0);
  assign reg_sel  = addr_rel[1:0];
  assign rd       = hit && bus.rd_wr_l;
  assign wr       = hit && !bus.rd_wr_l;
  assign wf       = DATAWIDTH'(bus.wr_data >> OFFSET);
  assign wr_cmd   = wr && (reg_sel == 2'd0);
  assign wr_done  = wr && (reg_sel == 2'd1);
  assign wr_tmo   = wr && (reg_sel == 2'd2);
  assign wr_abort = wr && (reg_sel == 2'd3);
  assign det      = in & ~in_q;

  always_comb begin
    field = out_q;
    case (reg_sel)
      2'd1:    field = done_q;
      2'd2:    field = tmo_q;
      default: field = out_q;
    endcase
    rdata_d = rd ? BUS_DW'(WIDE'(field) << OFFSET) : '0;
  end

  always_comb begin
    out_d    = out_q;
    done_set = '0;
    tmo_set  = '0;
    for (int i = 0; i < DATAWIDTH; i++) begin
      cnt_d[i] = '0;
      if (PULSE[i]) begin
        out_d[i]    = wr_cmd && wf[i];
        done_set[i] = wr_cmd && wf[i];
      end else begin
        // An edge with nothing pending is swallowed, and it also wins over a same-cycle set.
        if (det[i]) begin
          out_d[i]    = 1'b0;
          done_set[i] = out_q[i];
        end else if ((TIMEOUT != 0) && out_q[i] && (cnt_q[i] == TO_LAST)) begin
          out_d[i]   = 1'b0;
          tmo_set[i] = 1'b1;
        end else if (wr_abort && wf[i]) begin
          out_d[i] = 1'b0;
        end else if (wr_cmd && wf[i]) begin
          out_d[i] = 1'b1;
        end
        if ((TIMEOUT != 0) && out_q[i] && out_d[i]) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    done_d = done_set | (done_q & ~(wr_done ? wf : '0));
    tmo_d  = tmo_set  | (tmo_q  & ~(wr_tmo  ? wf : '0));
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      out_q   <= '0;
      done_q  <= '0;
      tmo_q   <= '0;
      in_q    <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DATAWIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      in_q    <= in;
      ack_q   <= hit;
      rdata_q <= rdata_d;
      for (int i = 0; i < DATAWIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out         = out_q;
  assign bus.ack     = ack_q;
  assign bus.rd_data = rdata_q;

endmodule
